// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch stage with a one-entry output
// register, branch redirect/flush and halt detection.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   imem_addr/imem_instr  combinational instruction memory read
//   branch_valid/target   redirect request (flushes the output slot)
//   out_valid/out_ready   handshake towards decode
//   out_instr/out_pc      fetched instruction and its address
//   halted                fetch stopped by a halt instruction
module fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_instr,
    input  logic        branch_valid,
    input  logic [15:0] branch_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    output logic        halted
);

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic        out_valid_n;
    logic [15:0] out_instr_n;
    logic [15:0] out_pc_n;
    logic        halted_n;
    logic        slot_free;
    logic        is_halt;

    assign imem_addr = pc;
    assign slot_free = !out_valid || out_ready;
    assign is_halt   = (imem_instr[15:12] == HALT_OPCODE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= 16'h0000;
            out_pc    <= 16'h0000;
            halted    <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            out_valid <= out_valid_n;
            out_instr <= out_instr_n;
            out_pc    <= out_pc_n;
            halted    <= halted_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        out_valid_n = out_valid;
        out_instr_n = out_instr;
        out_pc_n    = out_pc;
        halted_n    = halted;

        if (branch_valid) begin
            // Redirect flushes whatever sits in the output slot, even
            // if decode is accepting it this very cycle.
            state_n     = FETCH;
            pc_n        = branch_target;
            out_valid_n = 1'b0;
            halted_n    = 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (slot_free) begin
                        out_instr_n = imem_instr;
                        out_pc_n    = pc;
                        out_valid_n = 1'b1;
                        if (is_halt) begin
                            // pc parks on the halt address
                            state_n  = HALTED;
                            halted_n = 1'b1;
                        end else begin
                            pc_n = pc + 16'd1;
                        end
                    end
                end
                HALTED: begin
                    if (out_valid && out_ready) begin
                        out_valid_n = 1'b0;
                    end
                end
                default: begin
                    state_n = FETCH;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the address fetched first after reset.
REQ-002 SHALL have parameter HALT_OPCODE, default 4'hF, the value of instruction bits [15:12] that marks a halt instruction.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port imem_addr  output  16  address to the instruction memory.
REQ-006 SHALL have port imem_instr  input  16  instruction returned by the memory for imem_addr in the same cycle (combinational read).
REQ-007 SHALL have port branch_valid  input  1  redirect request from downstream.
REQ-008 SHALL have port branch_target  input  16  redirect address, sampled only when branch_valid=1.
REQ-009 SHALL have port out_valid  output  1  out_instr/out_pc hold a valid fetched instruction.
REQ-010 SHALL have port out_ready  input  1  decode stage accepts the output this cycle.
REQ-011 SHALL have port out_instr  output  16  fetched instruction.
REQ-012 SHALL have port out_pc  output  16  address that out_instr was fetched from.
REQ-013 SHALL have port halted  output  1  fetch stopped by a halt instruction.

Function
REQ-014 SHALL hold a 16-bit program counter pc and drive imem_addr = pc combinationally.
REQ-015 SHALL implement two states: FETCH and HALTED.
REQ-016 SHALL define "slot free" as out_valid=0 or out_ready=1.
REQ-017 In FETCH with slot free and branch_valid=0, SHALL register out_instr<=imem_instr, out_pc<=pc, out_valid<=1, pc<=pc+1.
REQ-018 In FETCH with slot not free and branch_valid=0, SHALL hold pc, out_instr, out_pc and out_valid unchanged (stall).
REQ-019 In FETCH with slot free, branch_valid=0 and out_valid=1, out_ready=0 never occurs; out_valid SHALL drop to 0 only in HALTED or on branch flush (see REQ-021, REQ-023).
REQ-020 SHALL give an instruction at address A on out_instr exactly one cycle after pc=A with slot free (one-cycle latency, one instruction per cycle when out_ready=1).
REQ-021 On branch_valid=1 in any state, SHALL set pc<=branch_target and out_valid<=0, capture nothing that cycle, go to FETCH, and clear halted; this flush overrides stall and any pending output even if out_ready=1.
REQ-022 When an instruction with bits[15:12]=HALT_OPCODE is captured (REQ-017), SHALL go to HALTED and set halted<=1; pc SHALL NOT increment (stays at the halt address).
REQ-023 In HALTED, SHALL hold pc, perform no capture, keep the halt instruction on the output until accepted, then drive out_valid<=0 after out_ready=1.
REQ-024 SHALL compute pc+1 modulo 2^16; 16'hFFFF wraps to 16'h0000 without any flag.
REQ-025 SHALL not change out_instr/out_pc while out_valid=1 and out_ready=0.

Reset
REQ-026 On rst=1 at a rising edge, SHALL set pc=RESET_PC, state=FETCH, out_valid=0, out_instr=16'h0000, out_pc=16'h0000, halted=0.
REQ-027 rst SHALL take priority over branch_valid and all other activity, including mid-stall and in HALTED.
REQ-028 First capture SHALL occur in the first cycle with rst=0, fetching RESET_PC.

Verification
REQ-029 Streaming: memory words 0..3 = 16'h1001,16'h2002,16'h3003,16'h4004, out_ready=1 -> out_valid rises one cycle after reset release; out_pc 0,1,2,3 with matching out_instr in consecutive cycles.
REQ-030 Stall: out_ready=0 for 3 cycles after address 1 captured -> out_pc=1, out_instr=16'h2002 held, imem_addr=2 held; on out_ready=1, address 2 delivered next cycle.
REQ-031 Branch: branch_valid=1, branch_target=16'h0010 while out_valid=1, out_ready=0 -> next cycle out_valid=0, imem_addr=16'h0010; following cycle out_pc=16'h0010.
REQ-032 Halt: word 2 = 16'hF000 -> after capture halted=1, imem_addr stays 2, out_instr=16'hF000 held until out_ready=1 then out_valid=0; branch_valid to 16'h0000 clears halted and resumes at 0.
REQ-033 Wrap: branch to 16'hFFFF, out_ready=1 -> out_pc 16'hFFFF then 16'h0000.
REQ-034 Reset mid-stall: out_valid=1, out_ready=0, pc=5, assert rst one cycle -> out_valid=0, out_pc=0, pc=RESET_PC, halted=0.
